// File: rtl/cic_ctrl_pkg.sv
// Shared types and default sizes for the CIC decimation sequencing controller.
package cic_ctrl_pkg;

    localparam int DEF_W  = 16;
    localparam int DEF_RW = 16;
    localparam int DEF_N  = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        COMB    = 2'd2,
        CAPTURE = 2'd3
    } state_t;

endpackage

// File: rtl/decim_ratio_counter.sv
// Input-sample counter against the active decimation ratio, with a pending ratio
// register that is applied only while idle or on the sample that closes a frame.
module decim_ratio_counter
    import cic_ctrl_pkg::*;
#(
    parameter int RW = DEF_RW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          count,
    input  logic          idle,
    input  logic          cfg_we,
    input  logic [RW-1:0] cfg_ratio,
    output logic          boundary
);

    logic [RW-1:0] cnt_reg;
    logic [RW-1:0] ratio_act_reg;
    logic [RW-1:0] ratio_pend_reg;
    logic          pend_flag_reg;
    logic [RW-1:0] cfg_value;
    logic          apply;

    // A ratio of zero is meaningless; treat it as "no decimation".
    assign cfg_value = (cfg_ratio == '0) ? RW'(1) : cfg_ratio;

    // >= rather than == keeps the counter self-recovering should cnt ever exceed the ratio.
    assign boundary  = count && (cnt_reg >= (ratio_act_reg - RW'(1)));
    assign apply     = idle || boundary;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg        <= '0;
            ratio_act_reg  <= RW'(1);
            ratio_pend_reg <= RW'(1);
            pend_flag_reg  <= 1'b0;
        end else begin
            if (clear || boundary) begin
                cnt_reg <= '0;
            end else if (count) begin
                cnt_reg <= cnt_reg + RW'(1);
            end

            if (cfg_we) begin
                ratio_pend_reg <= cfg_value;
            end

            // The closing boundary itself was judged against the old ratio above;
            // a write landing on that same cycle governs the next frame.
            if (apply) begin
                if (cfg_we) begin
                    ratio_act_reg <= cfg_value;
                end else if (pend_flag_reg) begin
                    ratio_act_reg <= ratio_pend_reg;
                end
                pend_flag_reg <= 1'b0;
            end else if (cfg_we) begin
                pend_flag_reg <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/cic_decim_ctrl.sv
// CIC decimation sequencer: integrator gating, per-frame comb stage sequencing,
// and a single-entry valid/ready output register with sticky overrun detection.
module cic_decim_ctrl
    import cic_ctrl_pkg::*;
#(
    parameter int W  = DEF_W,
    parameter int RW = DEF_RW,
    parameter int N  = DEF_N,
    parameter int SW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          i_clk,
    input  logic          i_reset_n,
    input  logic          i_enable,
    input  logic          i_ce,
    input  logic          i_cfg_we,
    input  logic [RW-1:0] i_cfg_ratio,
    input  logic [W-1:0]  i_comb_data,
    input  logic          i_ready,
    output logic          o_int_ce,
    output logic          o_comb_ce,
    output logic [SW-1:0] o_comb_sel,
    output logic [W-1:0]  o_data,
    output logic          o_valid,
    output logic          o_overrun,
    output logic          o_busy
);

    state_t        state_reg;
    state_t        state_next;
    logic [SW-1:0] stage_reg;
    logic [SW-1:0] stage_next;
    logic          busy_reg;
    logic [W-1:0]  data_reg;
    logic          valid_reg;
    logic          overrun_reg;
    logic          active;
    logic          boundary;
    logic          capture;
    logic          drop;

    assign active = (state_reg != IDLE) && i_enable;

    decim_ratio_counter #(
        .RW(RW)
    ) u_ratio_counter (
        .clk       (i_clk),
        .rst_n     (i_reset_n),
        .clear     (!active),
        .count     (active && i_ce),
        .idle      (state_reg == IDLE),
        .cfg_we    (i_cfg_we),
        .cfg_ratio (i_cfg_ratio),
        .boundary  (boundary)
    );

    always_comb begin
        state_next = state_reg;
        stage_next = stage_reg;
        capture    = 1'b0;
        drop       = 1'b0;
        case (state_reg)
            IDLE: begin
                state_next = RUN;
            end
            RUN: begin
                if (boundary) begin
                    state_next = COMB;
                    stage_next = '0;
                end
            end
            COMB: begin
                drop = boundary;
                if (stage_reg == SW'(N - 1)) begin
                    state_next = CAPTURE;
                    stage_next = '0;
                end else begin
                    stage_next = stage_reg + SW'(1);
                end
            end
            CAPTURE: begin
                drop       = boundary;
                capture    = 1'b1;
                state_next = RUN;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        // Disabling aborts any sequence in flight without touching the output register.
        if (!i_enable) begin
            state_next = IDLE;
            stage_next = '0;
            capture    = 1'b0;
            drop       = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_reg <= IDLE;
            stage_reg <= '0;
            busy_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            stage_reg <= stage_next;
            busy_reg  <= (state_next == COMB) || (state_next == CAPTURE);
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            data_reg    <= '0;
            valid_reg   <= 1'b0;
            overrun_reg <= 1'b0;
        end else begin
            if (capture) begin
                data_reg  <= i_comb_data;
                valid_reg <= 1'b1;
            end else if (valid_reg && i_ready) begin
                valid_reg <= 1'b0;
            end
            // A fresh loss event wins over a same-cycle config clear.
            if (drop || (capture && valid_reg && !i_ready)) begin
                overrun_reg <= 1'b1;
            end else if (i_cfg_we) begin
                overrun_reg <= 1'b0;
            end
        end
    end

    assign o_int_ce   = i_ce && (state_reg != IDLE);
    assign o_comb_ce  = (state_reg == COMB);
    assign o_comb_sel = (state_reg == COMB) ? stage_reg : '0;
    assign o_data     = data_reg;
    assign o_valid    = valid_reg;
    assign o_overrun  = overrun_reg;
    assign o_busy     = busy_reg;

endmodule

// File: tb/tb_cic_decim_ctrl.sv
// Directed bench for cic_decim_ctrl: stimulus pushes expected samples into a
// queue, a negedge monitor pops and compares on every valid/ready transfer.
module tb_cic_decim_ctrl;

    localparam int W  = 16;
    localparam int RW = 16;
    localparam int N  = 3;
    localparam int SW = 2;

    logic          i_clk = 1'b0;
    logic          i_reset_n;
    logic          i_enable;
    logic          i_ce;
    logic          i_cfg_we;
    logic [RW-1:0] i_cfg_ratio;
    logic [W-1:0]  i_comb_data;
    logic          i_ready;
    logic          o_int_ce;
    logic          o_comb_ce;
    logic [SW-1:0] o_comb_sel;
    logic [W-1:0]  o_data;
    logic          o_valid;
    logic          o_overrun;
    logic          o_busy;

    int            n_tests = 0;
    int            n_fail  = 0;
    logic [W-1:0]  exp_q[$];
    int            seq_starts[$];

    cic_decim_ctrl #(.W(W), .RW(RW), .N(N), .SW(SW)) dut (
        .i_clk       (i_clk),
        .i_reset_n   (i_reset_n),
        .i_enable    (i_enable),
        .i_ce        (i_ce),
        .i_cfg_we    (i_cfg_we),
        .i_cfg_ratio (i_cfg_ratio),
        .i_comb_data (i_comb_data),
        .i_ready     (i_ready),
        .o_int_ce    (o_int_ce),
        .o_comb_ce   (o_comb_ce),
        .o_comb_sel  (o_comb_sel),
        .o_data      (o_data),
        .o_valid     (o_valid),
        .o_overrun   (o_overrun),
        .o_busy      (o_busy)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Output-side scoreboard: one line per accepted sample.
    always @(negedge i_clk) begin
        if (i_reset_n && o_valid && i_ready) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL out_unexpected: got %0h, expected no sample", o_data);
            end else begin
                logic [W-1:0] e;
                e = exp_q.pop_front();
                if (o_data !== e) begin
                    n_fail++;
                    $display("FAIL out_data: got %0h, expected %0h", o_data, e);
                end else begin
                    $display("[TB] out sample %0h ok", o_data);
                end
            end
        end
    end

    task automatic restart(input logic [RW-1:0] r);
        i_enable    = 1'b0;
        i_ce        = 1'b0;
        i_cfg_we    = 1'b1;
        i_cfg_ratio = r;
        @(posedge i_clk); #1;
        i_cfg_we    = 1'b0;
        @(posedge i_clk); #1;
        i_enable    = 1'b1;
        @(posedge i_clk); #1;
    endtask

    // Step j drives comb data base+j; a sequence started at boundary b captures
    // in step b+N+1 and presents o_valid in step b+N+2.
    task automatic run_seq(input string tag, input int nsteps, input int nce,
                           input logic [W-1:0] base, input int push_mask,
                           input bit chk_valid, input int cfg_step,
                           input logic [RW-1:0] cfg_val);
        for (int j = 0; j < nsteps; j++) begin
            int exp_ce;
            int exp_sel;
            int exp_busy;
            int exp_valid;
            exp_ce    = 0;
            exp_sel   = 0;
            exp_busy  = 0;
            exp_valid = 0;
            i_ce        = (j < nce);
            i_comb_data = base + W'(j);
            i_cfg_we    = (j == cfg_step);
            i_cfg_ratio = cfg_val;
            for (int k = 0; k < seq_starts.size(); k++) begin
                int b;
                b = seq_starts[k];
                if (b == j && ((push_mask >> k) & 1) == 1)
                    exp_q.push_back(base + W'(j + N + 1));
                if (j > b && j <= b + N) begin
                    exp_ce  = 1;
                    exp_sel = j - b - 1;
                end
                if (j > b && j <= b + N + 1) exp_busy = 1;
                if (j == b + N + 2) exp_valid = 1;
            end
            #1;
            check($sformatf("%s int_ce j=%0d", tag, j), int'(o_int_ce), int'(j < nce));
            check($sformatf("%s comb_ce j=%0d", tag, j), int'(o_comb_ce), exp_ce);
            check($sformatf("%s comb_sel j=%0d", tag, j), int'(o_comb_sel), exp_sel);
            check($sformatf("%s busy j=%0d", tag, j), int'(o_busy), exp_busy);
            if (chk_valid)
                check($sformatf("%s valid j=%0d", tag, j), int'(o_valid), exp_valid);
            @(posedge i_clk); #1;
        end
        i_ce     = 1'b0;
        i_cfg_we = 1'b0;
    endtask

    initial begin
        i_reset_n   = 1'b0;
        i_enable    = 1'b0;
        i_ce        = 1'b0;
        i_cfg_we    = 1'b0;
        i_cfg_ratio = '0;
        i_comb_data = '0;
        i_ready     = 1'b1;
        repeat (2) @(posedge i_clk);
        #1;
        check("rst int_ce", int'(o_int_ce), 0);
        check("rst comb_ce", int'(o_comb_ce), 0);
        check("rst comb_sel", int'(o_comb_sel), 0);
        check("rst data", int'(o_data), 0);
        check("rst valid", int'(o_valid), 0);
        check("rst overrun", int'(o_overrun), 0);
        check("rst busy", int'(o_busy), 0);
        i_reset_n = 1'b1;
        @(posedge i_clk); #1;

        // R=5, i_ce every cycle: no overrun, one burst per 5 inputs
        restart(16'd5);
        seq_starts = '{4, 9, 14};
        run_seq("r5", 20, 15, 16'h1000, 7, 1'b1, -1, '0);
        check("r5 overrun", int'(o_overrun), 0);

        // R=4 < N+2: every other boundary is dropped
        restart(16'd4);
        seq_starts = '{3, 11};
        run_seq("r4", 18, 16, 16'h2000, 3, 1'b1, -1, '0);
        check("r4 overrun", int'(o_overrun), 1);

        // R=7 written mid-frame of R=3 takes effect on the following frame
        restart(16'd3);
        seq_starts = '{2, 9};
        run_seq("r3to7", 15, 10, 16'h3000, 3, 1'b1, 1, 16'd7);
        check("r3to7 overrun", int'(o_overrun), 0);

        // Downstream stalled over two frames: second capture overwrites
        restart(16'd5);
        i_ready = 1'b0;
        seq_starts = '{4, 9};
        run_seq("stall", 15, 10, 16'h4000, 2, 1'b0, -1, '0);
        check("stall valid", int'(o_valid), 1);
        check("stall overrun", int'(o_overrun), 1);
        i_ready = 1'b1;
        @(posedge i_clk); #1;
        check("stall drained", int'(o_valid), 0);
        i_cfg_we    = 1'b1;
        i_cfg_ratio = 16'd5;
        @(posedge i_clk); #1;
        i_cfg_we    = 1'b0;
        check("cfg clears overrun", int'(o_overrun), 0);

        // Disable during COMB stage 1: aborted, held output survives
        restart(16'd5);
        i_ready = 1'b0;
        seq_starts = '{4, 9};
        run_seq("abort", 11, 11, 16'h5000, 1, 1'b0, -1, '0);
        i_enable = 1'b0;
        i_ce     = 1'b1;
        #1;
        check("abort sel", int'(o_comb_sel), 1);
        check("abort comb_ce", int'(o_comb_ce), 1);
        @(posedge i_clk); #1;
        check("abort int_ce", int'(o_int_ce), 0);
        check("abort comb_ce idle", int'(o_comb_ce), 0);
        check("abort busy", int'(o_busy), 0);
        check("abort valid held", int'(o_valid), 1);
        @(posedge i_clk); #1;
        check("abort no capture", int'(o_overrun), 0);
        i_ce    = 1'b0;
        i_ready = 1'b1;
        @(posedge i_clk); #1;
        i_enable = 1'b1;
        i_ce     = 1'b1;
        #1;
        check("reenable idle int_ce", int'(o_int_ce), 0);
        @(posedge i_clk); #1;
        seq_starts = '{4};
        run_seq("reenable", 10, 5, 16'h6000, 1, 1'b1, -1, '0);

        // Asynchronous reset in the middle of CAPTURE
        restart(16'd5);
        i_ready = 1'b0;
        seq_starts = '{4, 9};
        run_seq("areset", 13, 13, 16'h7000, 0, 1'b0, -1, '0);
        i_ce = 1'b1;
        #1;
        check("areset pre busy", int'(o_busy), 1);
        check("areset pre valid", int'(o_valid), 1);
        #1;
        i_reset_n = 1'b0;
        #1;
        check("areset int_ce", int'(o_int_ce), 0);
        check("areset comb_ce", int'(o_comb_ce), 0);
        check("areset comb_sel", int'(o_comb_sel), 0);
        check("areset data", int'(o_data), 0);
        check("areset valid", int'(o_valid), 0);
        check("areset overrun", int'(o_overrun), 0);
        check("areset busy", int'(o_busy), 0);
        i_ce = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        check("queue empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
